// File: rtl/sram_pkg.sv
// sram_pkg: shared SRAM geometry, arbiter state encoding and loop-region bounds
package sram_pkg;
  localparam int SRAM_AW = 20;
  localparam int SRAM_DW = 16;
  localparam int LOOP_START_ADDR = 352000;
  localparam int LOOP_MAX_ADDR = 671999;
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RD_ADDR, S_RD_LATCH} arb_state_e;
endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester command/response bus plus SRAM pad pins
interface sram_arbiter_if import sram_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int AW = SRAM_AW,
  parameter int DW = SRAM_DW
);
  logic [NUM_REQ-1:0]    i_req;
  logic [NUM_REQ-1:0]    i_we_n;
  logic [NUM_REQ*AW-1:0] i_addr;
  logic [NUM_REQ*DW-1:0] i_wdata;
  logic [NUM_REQ-1:0]    o_grant;
  logic [DW-1:0]         o_rdata;
  logic [NUM_REQ-1:0]    o_rdata_valid;
  logic                  o_busy;
  logic [AW-1:0]         o_sram_addr;
  logic                  o_sram_we_n;
  logic [DW-1:0]         o_sram_wdata;
  logic [DW-1:0]         i_sram_rdata;
  modport slave (
    input  i_req, i_we_n, i_addr, i_wdata, i_sram_rdata,
    output o_grant, o_rdata, o_rdata_valid, o_busy, o_sram_addr, o_sram_we_n, o_sram_wdata
  );
  modport master (
    output i_req, i_we_n, i_addr, i_wdata, i_sram_rdata,
    input  o_grant, o_rdata, o_rdata_valid, o_busy, o_sram_addr, o_sram_we_n, o_sram_wdata
  );
endinterface

// File: rtl/sram_arbiter_rr_pick.sv
// rr_pick: round-robin picker, first set request after last_i with wraparound
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic               found_o,
  output logic [IW-1:0]      idx_o
);
  // Descending scan so the smallest offset from last_i is written last and wins
  always_comb begin
    found_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req_i[(int'(last_i) + i) % NUM_REQ]) begin
        found_o = 1'b1;
        idx_o = IW'((int'(last_i) + i) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter granting one SRAM word access per request;
// SRAM pins decode only from state and latched command registers
module sram_arbiter import sram_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int AW = SRAM_AW,
  parameter int DW = SRAM_DW
) (
  input logic i_clk,
  input logic i_rst,
  sram_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  arb_state_e state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, win;
  logic found;
  logic [AW-1:0] cmd_addr_q, cmd_addr_d;
  logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req_i(bus.i_req), .last_i(rr_q), .found_o(found), .idx_o(win)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      rr_q <= IW'(NUM_REQ - 1);
      cmd_addr_q <= '0;
      cmd_wdata_q <= '0;
      grant_q <= '0;
      rvalid_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      grant_q <= grant_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
    end
  end
  // rr_q doubles as the owner of the transaction in flight
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    cmd_addr_d = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    grant_d = '0;
    rvalid_d = '0;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: if (found) begin
        rr_d = win;
        cmd_addr_d = bus.i_addr[int'(win)*AW +: AW];
        cmd_wdata_d = bus.i_wdata[int'(win)*DW +: DW];
        grant_d = NUM_REQ'(1) << win;
        state_d = bus.i_we_n[win] ? S_RD_ADDR : S_WRITE;
      end
      S_WRITE: state_d = S_IDLE;
      S_RD_ADDR: state_d = S_RD_LATCH;
      S_RD_LATCH: begin
        rdata_d = bus.i_sram_rdata;
        rvalid_d = NUM_REQ'(1) << rr_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign bus.o_grant = grant_q;
  assign bus.o_rdata = rdata_q;
  assign bus.o_rdata_valid = rvalid_q;
  assign bus.o_busy = state_q != S_IDLE;
  assign bus.o_sram_we_n = state_q != S_WRITE;
  assign bus.o_sram_addr = state_q == S_IDLE ? '0 : cmd_addr_q;
  assign bus.o_sram_wdata = state_q == S_WRITE ? cmd_wdata_q : '0;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed plan plus random traffic against a transaction-level model
module tb_sram_arbiter;
  import sram_pkg::*;
  localparam int N = 4, AW = SRAM_AW, DW = SRAM_DW;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sram_arbiter_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) bus();
  sram_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  logic [N-1:0] req_v = '0, we_v = '1, auto_m = '0;
  logic [N*AW-1:0] addr_v = '0;
  logic [N*DW-1:0] wdata_v = '0;
  assign bus.i_req = req_v;
  assign bus.i_we_n = we_v;
  assign bus.i_addr = addr_v;
  assign bus.i_wdata = wdata_v;
  logic [DW-1:0] sram [0:(1<<AW)-1];
  logic pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) sram[pre_addr] <= pre_data;
    else if (!bus.o_sram_we_n) sram[bus.o_sram_addr] <= bus.o_sram_wdata;
  end
  assign bus.i_sram_rdata = sram[bus.o_sram_addr];
  int errors = 0, checks = 0;
  int cnt = 0, last = N - 1, m_owner = 0;
  logic m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rd = '0, m_rdata = '0;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [AW-1:0] known_q [$];
  int wait_n [N];
  int grant_log [$];
  logic [N-1:0] exp_g, exp_rv;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int pick(logic [N-1:0] r, int from);
    for (int i = 1; i <= N; i++) if (r[(from + i) % N]) return (from + i) % N;
    return -1;
  endfunction
  task automatic set_cmd(int k, logic we_n, logic [AW-1:0] a, logic [DW-1:0] d);
    req_v[k] = 1'b1;
    we_v[k] = we_n;
    addr_v[k*AW +: AW] = a;
    wdata_v[k*DW +: DW] = d;
  endtask
  task automatic new_cmd(int k);
    if (known_q.size() == 0 || $urandom_range(1) == 0)
      set_cmd(k, 1'b0, AW'(LOOP_START_ADDR + int'($urandom_range(63))), DW'($urandom));
    else
      set_cmd(k, 1'b1, known_q[$urandom_range(known_q.size() - 1)], DW'($urandom));
  endtask
  // One clock: advance the model on the inputs sampled at this edge, then compare
  task automatic step();
    int w;
    logic wr_ph, rd_ph;
    @(posedge clk);
    #1;
    exp_g = '0;
    exp_rv = '0;
    if (rst) begin
      cnt = 0; last = N - 1; m_rdata = '0;
      for (int k = 0; k < N; k++) wait_n[k] = 0;
    end else if (cnt == 0) begin
      if (req_v != '0) begin
        w = pick(req_v, last);
        for (int k = 0; k < N; k++) if (req_v[k] && k != w) wait_n[k]++;
        chk("wait_bound", wait_n[w] <= N - 1, 1);
        wait_n[w] = 0;
        last = w;
        exp_g[w] = 1'b1;
        grant_log.push_back(w);
        m_owner = w;
        m_wr = !we_v[w];
        m_addr = addr_v[w*AW +: AW];
        m_wdata = wdata_v[w*DW +: DW];
        if (m_wr) begin
          if (!ref_mem.exists(m_addr)) known_q.push_back(m_addr);
          ref_mem[m_addr] = m_wdata;
          cnt = 1;
        end else begin
          m_rd = ref_mem.exists(m_addr) ? ref_mem[m_addr] : '0;
          cnt = 2;
        end
      end
    end else begin
      cnt--;
      if (cnt == 0 && !m_wr) begin
        exp_rv[m_owner] = 1'b1;
        m_rdata = m_rd;
      end
    end
    wr_ph = cnt == 1 && m_wr;
    rd_ph = cnt > 0 && !m_wr;
    chk("grant", bus.o_grant, exp_g);
    chk("rdata_valid", bus.o_rdata_valid, exp_rv);
    chk("busy", bus.o_busy, cnt != 0);
    chk("rdata", bus.o_rdata, m_rdata);
    chk("sram_we_n", bus.o_sram_we_n, !wr_ph);
    chk("sram_addr", bus.o_sram_addr, (wr_ph || rd_ph) ? m_addr : '0);
    chk("sram_wdata", bus.o_sram_wdata, wr_ph ? m_wdata : '0);
    for (int k = 0; k < N; k++) if (exp_g[k]) begin
      if (auto_m[k]) new_cmd(k);
      else req_v[k] = 1'b0;
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 60 && !(req_v == '0 && cnt == 0); i++) step();
    chk("drain_timeout", req_v == '0 && cnt == 0, 1);
  endtask
  task automatic run_until_grants(int n);
    for (int i = 0; i < 100 && grant_log.size() < n; i++) step();
    chk("grant_timeout", grant_log.size(), n);
  endtask
  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    step();
    step();
    chk("rst_grant", bus.o_grant, 0);
    chk("rst_rvalid", bus.o_rdata_valid, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_we_n", bus.o_sram_we_n, 1);
    chk("rst_addr", bus.o_sram_addr, 0);
    chk("rst_rdata", bus.o_rdata, 0);
    rst = 1'b0;
    // single write
    set_cmd(1, 1'b0, AW'(LOOP_START_ADDR), 16'h1234);
    step();
    chk("wr_grant", bus.o_grant, 4'b0010);
    chk("wr_we_n", bus.o_sram_we_n, 0);
    step();
    chk("wr_idle", bus.o_busy, 0);
    chk("wr_sram", sram[AW'(LOOP_START_ADDR)], 16'h1234);
    // single read of a preloaded word
    pre_we = 1'b1; pre_addr = AW'(LOOP_START_ADDR + 5); pre_data = 16'hBEEF;
    step();
    pre_we = 1'b0;
    ref_mem[pre_addr] = 16'hBEEF;
    known_q.push_back(pre_addr);
    set_cmd(2, 1'b1, pre_addr, '0);
    step();
    chk("rd_grant", bus.o_grant, 4'b0100);
    chk("rd_we_n1", bus.o_sram_we_n, 1);
    step();
    chk("rd_we_n2", bus.o_sram_we_n, 1);
    step();
    chk("rd_data", bus.o_rdata, 16'hBEEF);
    chk("rd_valid", bus.o_rdata_valid, 4'b0100);
    // fairness from reset
    rst = 1'b1;
    auto_m = '1;
    for (int k = 0; k < N; k++) new_cmd(k);
    step();
    rst = 1'b0;
    grant_log.delete();
    run_until_grants(8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) chk("fair_order", grant_log[i], i % N);
    auto_m = '0;
    drain();
    // contention after wrap
    set_cmd(3, 1'b0, AW'(LOOP_START_ADDR + 9), 16'h0303);
    grant_log.delete();
    run_until_grants(1);
    set_cmd(1, 1'b0, AW'(LOOP_START_ADDR + 10), 16'h0101);
    set_cmd(3, 1'b1, AW'(LOOP_START_ADDR + 9), '0);
    run_until_grants(3);
    if (grant_log.size() >= 3) begin
      chk("wrap_first", grant_log[1], 1);
      chk("wrap_second", grant_log[2], 3);
    end
    drain();
    // reset during S_RD_ADDR
    set_cmd(1, 1'b1, AW'(LOOP_START_ADDR + 5), '0);
    grant_log.delete();
    run_until_grants(1);
    chk("mid_busy", bus.o_busy, 1);
    rst = 1'b1;
    step();
    chk("mrst_grant", bus.o_grant, 0);
    chk("mrst_rvalid", bus.o_rdata_valid, 0);
    chk("mrst_busy", bus.o_busy, 0);
    chk("mrst_addr", bus.o_sram_addr, 0);
    chk("mrst_rdata", bus.o_rdata, 0);
    rst = 1'b0;
    step();
    chk("mrst_no_valid", bus.o_rdata_valid, 0);
    grant_log.delete();
    set_cmd(2, 1'b0, AW'(LOOP_START_ADDR + 20), 16'h2222);
    set_cmd(0, 1'b0, AW'(LOOP_START_ADDR + 21), 16'h0000);
    run_until_grants(2);
    if (grant_log.size() >= 2) begin
      chk("mrst_prio0", grant_log[0], 0);
      chk("mrst_prio2", grant_log[1], 2);
    end
    drain();
    // back-to-back write/read pairs from requester 0
    for (int i = 0; i < 100; i++) begin
      a = AW'($urandom_range((1 << AW) - 1));
      d = DW'($urandom);
      set_cmd(0, 1'b0, a, d);
      drain();
      set_cmd(0, 1'b1, a, '0);
      drain();
      chk("b2b_rdata", bus.o_rdata, d);
    end
    // random multi-requester traffic
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) if (!req_v[k] && $urandom_range(2) == 0) new_cmd(k);
      step();
    end
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
